ir_nec_rx: RTL and testbench
============================

Name: ir_nec_rx

Overview:
- NEC infrared frame decoder. It is the receive-side counterpart of the TV-B-Gone transmitter.
- Input is the demodulated output of an IR receiver module (TSOP-style, idle high, mark = low).
- It measures mark and space durations in 10 us ticks and validates them against the NEC timing windows.
- It outputs decoded address/command, repeat-code and error pulses for the board top level (status LEDs, debug).

Parameters:
- CLK_HZ, 8000000, clock_in frequency; tick divider = CLK_HZ/100000 (80 at 8 MHz).
- FILTER_CYCLES, 4, number of consecutive equal synchronized samples required before the filtered level changes.
- CHECK_ADDR, 1, 1 = require addr_hi == ~addr_lo (standard NEC); 0 = accept a 16-bit extended address.

Ports:
- clock_in  input  1  system clock, single domain.
- resetn_in  input  1  synchronous reset, active-low.
- ir_in  input  1  raw demodulated IR, asynchronous; 0 = carrier present (mark).
- busy_out  output  1  high from leader-mark acceptance until frame end or abort.
- valid_out  output  1  one-cycle pulse; a full frame was decoded and addr_out/cmd_out were updated.
- repeat_out  output  1  one-cycle pulse; a repeat code was received, addr_out/cmd_out hold the last frame.
- error_out  output  1  one-cycle pulse; a frame was aborted after its leader was accepted.
- addr_out  output  16  decoded address, byte0 in [7:0], byte1 in [15:8].
- cmd_out  output  8  decoded command.

Behaviour:
- Reset (resetn_in low at a clock edge): all outputs 0, state IDLE, have_frame = 0, tick and duration counters 0, filtered level = 1. Reset dominates every other event, including mid-frame.
- Input path: 2-FF synchronizer, then the FILTER_CYCLES glitch filter, then edge detect. The filtered level lags ir_in by 2+FILTER_CYCLES cycles.
- Tick: prescaler wraps at CLK_HZ/100000-1. Both the prescaler and dur_cnt (11 bit) clear on every filtered edge. dur_cnt increments per tick and saturates at 2047.
- Windows in ticks, inclusive:
  - LEADER_MARK 800..1000
  - LEADER_SPACE 400..500
  - REPEAT_SPACE 200..250
  - BIT_MARK 40..75
  - SPACE0 40..75
  - SPACE1 140..200
- States: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, REP_STOP.
- Transitions:
  - IDLE: falling edge -> LEAD_MARK.
  - LEAD_MARK: on rising edge, dur in LEADER_MARK -> LEAD_SPACE and busy_out = 1. Otherwise -> IDLE silently (noise, no error).
  - LEAD_SPACE: on falling edge:
    - dur in LEADER_SPACE -> BIT_MARK, bit_idx = 0.
    - dur in REPEAT_SPACE -> REP_STOP.
    - otherwise -> error.
  - BIT_MARK: on rising edge, dur in BIT_MARK -> BIT_SPACE, else error.
  - BIT_SPACE: on falling edge:
    - SPACE0 shifts in 0; SPACE1 shifts in 1. Shift is LSB first into a 32-bit register: bits 0-7 addr_lo, 8-15 addr_hi, 16-23 cmd, 24-31 ncmd.
    - After bit_idx 31 -> STOP_MARK, else bit_idx++ and -> BIT_MARK.
    - Any other duration -> error.
    - dur reaching 201 with no edge -> error immediately (timeout).
  - STOP_MARK: on rising edge with dur in BIT_MARK:
    - Checks: cmd == ~ncmd, and (CHECK_ADDR == 0 or addr_hi == ~addr_lo).
    - Pass: next cycle addr_out/cmd_out load, valid_out pulses, have_frame = 1.
    - Fail: error.
    - Either way -> IDLE.
  - REP_STOP: on rising edge with dur in BIT_MARK, repeat_out pulses if have_frame == 1. If have_frame == 0 the code is dropped silently. Bad duration -> error. -> IDLE.
- Timeout: in any mark state, dur reaching 1001 -> error (stuck-low input).
- Error: error_out pulses one cycle, busy_out drops, -> IDLE. addr_out/cmd_out and have_frame are unchanged.
- Latency: valid_out/repeat_out/error_out are registered and assert 1 cycle after the deciding filtered edge. busy_out falls on the same cycle.
- valid_out, repeat_out and error_out are mutually exclusive. Any of them is followed by at least one IDLE cycle.
- A falling edge on the same cycle as a decision is not lost: IDLE samples the filtered level and enters LEAD_MARK if the level is already low.

Decomposition:
- Package ir_nec_pkg:
  - state enum state_t.
  - window localparams: LEADER_MARK_MIN/MAX, LEADER_SPACE_MIN/MAX, REPEAT_SPACE_MIN/MAX, BIT_MARK_MIN/MAX, SPACE0_MIN/MAX, SPACE1_MIN/MAX.
  - DUR_W = 11, TICK_US = 10.
- Sub-module ir_edge_filter: synchronizer, glitch filter, rise/fall pulses, parameter FILTER_CYCLES.
- Expected size: about 220 lines total.

Test Plan:
- Frame addr 0x04, cmd 0x08 (bytes 04 FB 08 F7) with nominal timing -> exactly one valid_out pulse, addr_out 0xFB04, cmd_out 0x08, busy_out high for the frame span, no error_out.
- Same frame, then repeat code (9 ms mark, 2.25 ms space, 560 us mark) 40 ms later -> repeat_out pulse, addr_out/cmd_out unchanged. Repeat code directly after reset -> no pulses at all.
- Frame with ncmd = 0xF6 -> error_out pulse, no valid_out, previous addr_out/cmd_out retained. The same frame with CHECK_ADDR = 0 and addr bytes 0x12 0x34 still errors on cmd. Bytes 12 34 08 F7 with CHECK_ADDR = 0 -> valid, addr_out 0x3412.
- Timing margins: all durations at +10% -> valid. Leader mark 7 ms -> silent return to IDLE, no pulses. Bit space 2.5 ms -> error_out about 2.01 ms into the space.
- 1 us glitches (8 cycles at FILTER_CYCLES = 16) injected into spaces -> frame still decodes. resetn_in low during bit 12 -> all outputs 0, and the next clean frame decodes correctly.

Source files
------------

// File: rtl/ir_nec_pkg.sv
// Shared types and NEC timing windows for the IR receiver.
// All durations are in 10 us ticks; windows are inclusive.
package ir_nec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        REP_STOP
    } state_t;

    localparam int DUR_W   = 11;
    localparam int TICK_US = 10;

    localparam int LEADER_MARK_MIN  = 800;
    localparam int LEADER_MARK_MAX  = 1000;
    localparam int LEADER_SPACE_MIN = 400;
    localparam int LEADER_SPACE_MAX = 500;
    localparam int REPEAT_SPACE_MIN = 200;
    localparam int REPEAT_SPACE_MAX = 250;
    localparam int BIT_MARK_MIN     = 40;
    localparam int BIT_MARK_MAX     = 75;
    localparam int SPACE0_MIN       = 40;
    localparam int SPACE0_MAX       = 75;
    localparam int SPACE1_MIN       = 140;
    localparam int SPACE1_MAX       = 200;

    localparam int MARK_TIMEOUT       = LEADER_MARK_MAX + 1;
    localparam int SPACE_TIMEOUT      = SPACE1_MAX + 1;
    localparam int LEAD_SPACE_TIMEOUT = LEADER_SPACE_MAX + 1;

    function automatic logic in_win(input logic [DUR_W-1:0] d, input int lo, input int hi);
        return (int'(d) >= lo) && (int'(d) <= hi);
    endfunction

endpackage

// File: rtl/ir_edge_filter.sv
// Synchronizes the raw IR input, rejects pulses shorter than FILTER_CYCLES
// and emits one-cycle rise/fall strobes aligned with the filtered level change.
module ir_edge_filter #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic ir_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          rise_q;
    logic          fall_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], ir_i};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            // any sample matching the current level restarts the run count
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
                cnt_q   <= '0;
                level_q <= sync_q[1];
                rise_q  <= sync_q[1];
                fall_q  <= ~sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ir_nec_rx.sv
// NEC IR frame decoder: measures filtered mark/space widths in 10 us ticks
// and reports frames, repeat codes and aborted frames as one-cycle pulses.
module ir_nec_rx
    import ir_nec_pkg::*;
#(
    parameter int CLK_HZ        = 8000000,
    parameter int FILTER_CYCLES = 4,
    parameter bit CHECK_ADDR    = 1'b1
) (
    input  logic        clock_in,
    input  logic        resetn_in,
    input  logic        ir_in,
    output logic        busy_out,
    output logic        valid_out,
    output logic        repeat_out,
    output logic        error_out,
    output logic [15:0] addr_out,
    output logic [7:0]  cmd_out
);
    localparam int DIV = CLK_HZ / (1000000 / TICK_US);
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic level, rise, fall;

    ir_edge_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter (
        .clk_i   (clock_in),
        .rst_n_i (resetn_in),
        .ir_i    (ir_in),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [4:0]       bit_q, bit_d;
    logic [31:0]      shift_q, shift_d;
    logic [15:0]      addr_q, addr_d;
    logic [7:0]       cmd_q, cmd_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             repeat_q, repeat_d;
    logic             error_q, error_d;
    logic             have_q, have_d;

    logic tick, bit_win, s0, s1, mark_to, space_to, frame_ok, abort;

    assign tick     = (presc_q == PW'(DIV - 1));
    assign presc_d  = (rise || fall || tick) ? '0 : presc_q + 1'b1;
    assign dur_d    = (rise || fall) ? '0 : ((tick && (dur_q != '1)) ? dur_q + 1'b1 : dur_q);
    assign bit_win  = in_win(dur_q, BIT_MARK_MIN, BIT_MARK_MAX);
    assign s0       = in_win(dur_q, SPACE0_MIN, SPACE0_MAX);
    assign s1       = in_win(dur_q, SPACE1_MIN, SPACE1_MAX);
    assign mark_to  = (int'(dur_q) >= MARK_TIMEOUT);
    assign space_to = (int'(dur_q) >= SPACE_TIMEOUT);
    assign frame_ok = (shift_q[23:16] == ~shift_q[31:24]) &&
                      (!CHECK_ADDR || (shift_q[15:8] == ~shift_q[7:0]));

    always_ff @(posedge clock_in) begin
        if (!resetn_in) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            dur_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            addr_q   <= '0;
            cmd_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            repeat_q <= 1'b0;
            error_q  <= 1'b0;
            have_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            dur_q    <= dur_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            addr_q   <= addr_d;
            cmd_q    <= cmd_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            repeat_q <= repeat_d;
            error_q  <= error_d;
            have_q   <= have_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        repeat_d = 1'b0;
        error_d  = 1'b0;
        addr_d   = addr_q;
        cmd_d    = cmd_q;
        have_d   = have_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        abort    = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                // level rather than edge, so a fall during a decision cycle is kept
                if (!level) state_d = LEAD_MARK;
            end
            LEAD_MARK: begin
                if (rise) begin
                    if (in_win(dur_q, LEADER_MARK_MIN, LEADER_MARK_MAX)) begin
                        state_d = LEAD_SPACE;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            LEAD_SPACE: begin
                if (fall) begin
                    if (in_win(dur_q, LEADER_SPACE_MIN, LEADER_SPACE_MAX)) begin
                        state_d = BIT_MARK;
                        bit_d   = '0;
                    end else if (in_win(dur_q, REPEAT_SPACE_MIN, REPEAT_SPACE_MAX)) begin
                        state_d = REP_STOP;
                    end else begin
                        abort = 1'b1;
                    end
                end else if (int'(dur_q) >= LEAD_SPACE_TIMEOUT) begin
                    abort = 1'b1;
                end
            end
            BIT_MARK: begin
                if (rise) begin
                    if (bit_win) state_d = BIT_SPACE;
                    else         abort   = 1'b1;
                end else if (mark_to) begin
                    abort = 1'b1;
                end
            end
            BIT_SPACE: begin
                if (fall) begin
                    if (s0 || s1) begin
                        shift_d = {s1, shift_q[31:1]};
                        if (bit_q == 5'd31) begin
                            state_d = STOP_MARK;
                        end else begin
                            bit_d   = bit_q + 5'd1;
                            state_d = BIT_MARK;
                        end
                    end else begin
                        abort = 1'b1;
                    end
                end else if (space_to) begin
                    abort = 1'b1;
                end
            end
            STOP_MARK: begin
                if (rise) begin
                    if (bit_win && frame_ok) begin
                        valid_d = 1'b1;
                        addr_d  = shift_q[15:0];
                        cmd_d   = shift_q[23:16];
                        have_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        abort = 1'b1;
                    end
                end else if (mark_to) begin
                    abort = 1'b1;
                end
            end
            REP_STOP: begin
                if (rise) begin
                    if (bit_win) begin
                        repeat_d = have_q;
                        busy_d   = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        abort = 1'b1;
                    end
                end else if (mark_to) begin
                    abort = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            error_d = 1'b1;
        end
    end

    assign busy_out   = busy_q;
    assign valid_out  = valid_q;
    assign repeat_out = repeat_q;
    assign error_out  = error_q;
    assign addr_out   = addr_q;
    assign cmd_out    = cmd_q;

endmodule

// File: tb/tb_ir_nec_rx.sv
// Bench for ir_nec_rx: two decoders (address check on/off) share one IR line;
// expected pulses are queued per decoder and matched as they appear.
module tb_ir_nec_rx;

    logic clk = 1'b0;
    logic rstn;
    logic ir;
    logic [1:0]       v, r, e, b;
    logic [1:0][15:0] a;
    logic [1:0][7:0]  c;

    int checks = 0;
    int passes = 0;

    localparam logic [2:0] K_VALID = 3'b100;
    localparam logic [2:0] K_REP   = 3'b010;
    localparam logic [2:0] K_ERR   = 3'b001;

    typedef struct {
        int         dut;
        logic [2:0] kind;
        logic [15:0] addr;
        logic [7:0]  cmd;
    } ev_t;

    ev_t        exp_q[$];
    logic [15:0] m_addr [2];
    logic [7:0]  m_cmd  [2];
    bit          m_have [2];

    always #5 clk = ~clk;

    // 100 kHz clock gives one tick per cycle, keeping frames short in simulation
    ir_nec_rx #(.CLK_HZ(100000), .FILTER_CYCLES(16), .CHECK_ADDR(1'b1)) dut0 (
        .clock_in(clk), .resetn_in(rstn), .ir_in(ir),
        .busy_out(b[0]), .valid_out(v[0]), .repeat_out(r[0]), .error_out(e[0]),
        .addr_out(a[0]), .cmd_out(c[0])
    );

    ir_nec_rx #(.CLK_HZ(100000), .FILTER_CYCLES(16), .CHECK_ADDR(1'b0)) dut1 (
        .clock_in(clk), .resetn_in(rstn), .ir_in(ir),
        .busy_out(b[1]), .valid_out(v[1]), .repeat_out(r[1]), .error_out(e[1]),
        .addr_out(a[1]), .cmd_out(c[1])
    );

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (v[d] | r[d] | e[d]) begin
                int   k;
                ev_t  ev;
                logic [2:0] obs;
                k   = -1;
                obs = {v[d], r[d], e[d]};
                for (int i = 0; i < exp_q.size(); i++)
                    if (k < 0 && exp_q[i].dut == d) k = i;
                checks++;
                if (k < 0) begin
                    $display("FAIL unexpected_pulse dut%0d: got v/r/e=%b addr=%h cmd=%h, required no pulse",
                             d, obs, a[d], c[d]);
                end else begin
                    ev = exp_q[k];
                    exp_q.delete(k);
                    if (obs !== ev.kind || a[d] !== ev.addr || c[d] !== ev.cmd)
                        $display("FAIL pulse dut%0d: got v/r/e=%b addr=%h cmd=%h, required v/r/e=%b addr=%h cmd=%h",
                                 d, obs, a[d], c[d], ev.kind, ev.addr, ev.cmd);
                    else
                        passes++;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

    task automatic hold(input logic lvl, input int n);
        ir = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic space(input int n, input bit g);
        if (g) begin
            hold(1'b1, n / 2);
            hold(1'b0, 8);
            hold(1'b1, n - n / 2 - 8);
        end else begin
            hold(1'b1, n);
        end
    endtask

    task automatic push(input int d, input logic [2:0] kind);
        ev_t ev;
        ev.dut  = d;
        ev.kind = kind;
        ev.addr = m_addr[d];
        ev.cmd  = m_cmd[d];
        exp_q.push_back(ev);
    endtask

    task automatic expect_frame(input logic [31:0] w);
        bit ok_cmd, ok_addr;
        ok_cmd  = (w[23:16] == ~w[31:24]);
        ok_addr = (w[15:8] == ~w[7:0]);
        for (int d = 0; d < 2; d++) begin
            if (ok_cmd && (d == 1 || ok_addr)) begin
                m_addr[d] = w[15:0];
                m_cmd[d]  = w[23:16];
                m_have[d] = 1'b1;
                push(d, K_VALID);
            end else begin
                push(d, K_ERR);
            end
        end
    endtask

    task automatic send_frame(input logic [31:0] w, input int pct, input int lead,
                              input bit g, input int rst_bit, input logic exp_busy);
        hold(1'b0, lead * pct / 100);
        space(450 * pct / 100, g);
        checks++;
        if (b !== {2{exp_busy}})
            $display("FAIL busy_after_leader: got %b, required %b", b, {2{exp_busy}});
        else
            passes++;
        for (int i = 0; i < 32; i++) begin
            if (i == rst_bit) begin
                rstn = 1'b0;
                hold(1'b1, 3);
                checks++;
                if ({v, r, e, b} !== 8'h00 || a !== '0 || c !== '0)
                    $display("FAIL reset_mid_frame: got vreb=%b addr=%h cmd=%h, required all zero",
                             {v, r, e, b}, a, c);
                else
                    passes++;
                hold(1'b1, 20);
                rstn = 1'b1;
                for (int d = 0; d < 2; d++) begin
                    m_addr[d] = '0;
                    m_cmd[d]  = '0;
                    m_have[d] = 1'b0;
                end
                hold(1'b1, 100);
                return;
            end
            hold(1'b0, 56 * pct / 100);
            space((w[i] ? 169 : 56) * pct / 100, g);
        end
        hold(1'b0, 56 * pct / 100);
        hold(1'b1, 100);
    endtask

    task automatic send_repeat(input logic exp_busy);
        hold(1'b0, 900);
        hold(1'b1, 225);
        checks++;
        if (b !== {2{exp_busy}})
            $display("FAIL busy_in_repeat: got %b, required %b", b, {2{exp_busy}});
        else
            passes++;
        hold(1'b0, 56);
        hold(1'b1, 100);
    endtask

    task automatic drained(input string name);
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL %s_missing_pulses: got %0d pending, required 0", name, exp_q.size());
        else
            passes++;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        ir   = 1'b1;
        for (int d = 0; d < 2; d++) begin
            m_addr[d] = '0;
            m_cmd[d]  = '0;
            m_have[d] = 1'b0;
        end
        hold(1'b1, 5);
        checks++;
        if ({v, r, e, b} !== 8'h00 || a !== '0 || c !== '0)
            $display("FAIL reset_state: got vreb=%b addr=%h cmd=%h, required all zero", {v, r, e, b}, a, c);
        else
            passes++;
        rstn = 1'b1;
        hold(1'b1, 50);
    endtask

    task automatic test_repeat_no_frame();
        send_repeat(1'b1);
        drained("repeat_no_frame");
    endtask

    task automatic test_frame();
        expect_frame(32'hF708FB04);
        send_frame(32'hF708FB04, 100, 900, 1'b0, -1, 1'b1);
        checks++;
        if (b !== 2'b00)
            $display("FAIL busy_after_frame: got %b, required 00", b);
        else
            passes++;
        drained("frame");
    endtask

    task automatic test_repeat();
        hold(1'b1, 4000);
        for (int d = 0; d < 2; d++)
            if (m_have[d]) push(d, K_REP);
        send_repeat(1'b1);
        drained("repeat");
    endtask

    task automatic test_bad_cmd();
        expect_frame(32'hF608FB04);
        send_frame(32'hF608FB04, 100, 900, 1'b0, -1, 1'b1);
        drained("bad_cmd");
        expect_frame(32'hF6083412);
        send_frame(32'hF6083412, 100, 900, 1'b0, -1, 1'b1);
        drained("bad_cmd_ext");
        expect_frame(32'hF7083412);
        send_frame(32'hF7083412, 100, 900, 1'b0, -1, 1'b1);
        drained("ext_addr");
    endtask

    task automatic test_margin();
        expect_frame(32'hBA45FF00);
        send_frame(32'hBA45FF00, 110, 900, 1'b0, -1, 1'b1);
        drained("margin");
    endtask

    task automatic test_short_leader();
        send_frame(32'hF708FB04, 100, 700, 1'b0, -1, 1'b0);
        drained("short_leader");
    endtask

    task automatic test_space_timeout();
        int t;
        push(0, K_ERR);
        push(1, K_ERR);
        hold(1'b0, 900);
        hold(1'b1, 450);
        for (int i = 0; i < 3; i++) begin
            hold(1'b0, 56);
            hold(1'b1, (i == 2) ? 169 : 56);
        end
        hold(1'b0, 56);
        ir = 1'b1;
        t  = 0;
        while (e[0] !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t < 211 || t > 231)
            $display("FAIL space_timeout_latency: got %0d cycles, required 211..231", t);
        else
            passes++;
        hold(1'b1, 40);
        hold(1'b0, 56);
        hold(1'b1, 100);
        drained("space_timeout");
    endtask

    task automatic test_glitch();
        expect_frame(32'hEF10DF20);
        send_frame(32'hEF10DF20, 100, 900, 1'b1, -1, 1'b1);
        drained("glitch");
    endtask

    task automatic test_reset_mid_frame();
        send_frame(32'hF708FB04, 100, 900, 1'b0, 12, 1'b1);
        drained("reset_mid_frame");
        expect_frame(32'h7F80BF40);
        send_frame(32'h7F80BF40, 100, 900, 1'b0, -1, 1'b1);
        drained("frame_after_reset");
    endtask

    initial begin
        test_reset();
        test_repeat_no_frame();
        test_frame();
        test_repeat();
        test_bad_cmd();
        test_margin();
        test_short_leader();
        test_space_timeout();
        test_glitch();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
